// File: rtl/mem_if_pkg.sv
// Shared definitions for the unified-memory request interface.
package mem_if_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_LINE_W = 64;

    // Responder state encoding
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    // Latched operation type
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous line RAM with a registered read port.
// The array itself is never reset; only the read register is, so rdata
// comes out of reset as zero and holds its value between reads.
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LINE_W = MEM_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    // Write port: commit a line when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: loads only on a read, otherwise holds the last line
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Multi-cycle unified main memory responder: accepts one line read or
// write, waits a fixed latency on a down-counter, commits it, pulses rdy.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   MEM_IDLE | waiting; re|we accepted on the next edge
//   MEM_BUSY | request latched, counting down to the commit edge
//   MEM_DONE | access committed, rdy high; requests not accepted
module unified_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LINE_W  = MEM_LINE_W,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata,
    output logic              rdy,
    output logic              busy,
    output logic              req_err
);

    mem_state_t        state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              op_q;
    logic              accept;
    logic              commit;
    logic              ram_we;
    logic              ram_re;

    // Next-state decode and status outputs
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        rdy       = 1'b0;
        busy      = 1'b1;
        case (state)
            MEM_IDLE: begin
                busy = 1'b0;
                if (re || we) begin
                    accept    = 1'b1;
                    state_nxt = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = MEM_DONE;
                end
            end
            MEM_DONE: begin
                rdy       = 1'b1;
                state_nxt = MEM_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = MEM_IDLE;
            end
        endcase
    end

    // State register, latency counter and request latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MEM_IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
            req_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_err <= accept && re && we;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                op_q    <= we ? OP_WR : OP_RD;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == MEM_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // A reset landing on the commit edge must abort the access
    assign ram_we = commit && (op_q == OP_WR) && !rst;
    assign ram_re = commit && (op_q == OP_RD) && !rst;

    mem_line_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder with LATENCY=4.
module tb_unified_mem_responder;

    localparam int ADDR_W  = 14;
    localparam int LINE_W  = 64;
    localparam int LATENCY = 4;

    logic              clk;
    logic              rst;
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              rdy;
    logic              busy;
    logic              req_err;

    int checks   = 0;
    int failures = 0;

    unified_mem_responder #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .re      (re),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rdy     (rdy),
        .busy    (busy),
        .req_err (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, wait for rdy, drop the request in the
    // rdy cycle and step into the following IDLE cycle. lat counts edges
    // from the accepting edge to the edge that raised rdy (-1 on timeout).
    task automatic do_req(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] d, input bit scramble,
                          output int lat, output int errs, output int busy_bad,
                          output logic [LINE_W-1:0] rd);
        re = r; we = w; addr = a; wdata = d;
        lat = -1; errs = 0; busy_bad = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (req_err) errs++;
            if (!busy) busy_bad++;
            if (scramble && n == 1) begin
                addr  = a + 14'h0010;
                wdata = ~d;
                we    = 1'b1;
            end
            if (rdy) begin
                lat = n - 1;
                break;
            end
        end
        rd = rdata;
        re = 1'b0; we = 1'b0;
        tick();
        if (busy) busy_bad++;
    endtask

    int               lat, errs, bb, nrdy;
    logic [LINE_W-1:0] rd;
    logic [17:0]       rdy_vec, busy_vec, rdy_exp, busy_exp;

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick();
        chk("reset_rdy",     {63'd0, rdy},     64'd0);
        chk("reset_busy",    {63'd0, busy},    64'd0);
        chk("reset_req_err", {63'd0, req_err}, 64'd0);
        chk("reset_rdata",   rdata,            64'd0);
        rst = 1'b0;
        tick();

        // Write then read back
        do_req(1'b0, 1'b1, 14'h0010, 64'h1111_2222_3333_4444, 1'b0, lat, errs, bb, rd);
        chk("wr10_lat",  64'(lat), 64'(LATENCY));
        chk("wr10_err",  64'(errs), 64'd0);
        chk("wr10_busy", 64'(bb), 64'd0);
        chk("wr10_rdata_untouched", rd, 64'd0);
        do_req(1'b1, 1'b0, 14'h0010, 64'h0, 1'b0, lat, errs, bb, rd);
        chk("rd10_lat",  64'(lat), 64'(LATENCY));
        chk("rd10_data", rd, 64'h1111_2222_3333_4444);
        chk("rd10_busy", 64'(bb), 64'd0);

        // re held continuously: accept, 4 BUSY, DONE (rdy), IDLE, accept...
        // so rdy repeats every LATENCY+2 edges and busy drops only in IDLE.
        re = 1'b1; addr = 14'h0010;
        for (int k = 1; k <= 18; k++) begin
            tick();
            rdy_vec[k-1]  = rdy;
            busy_vec[k-1] = busy;
            rdy_exp[k-1]  = ((k % (LATENCY + 2)) == LATENCY + 1);
            busy_exp[k-1] = ((k % (LATENCY + 2)) != 0);
        end
        re = 1'b0;
        tick();
        chk("stream_rdy",   64'(rdy_vec),  64'(rdy_exp));
        chk("stream_busy",  64'(busy_vec), 64'(busy_exp));
        chk("stream_rdata", rdata, 64'h1111_2222_3333_4444);

        // Mid-operation changes to addr/wdata/we are ignored
        do_req(1'b0, 1'b1, 14'h0030, 64'h5555_6666_7777_8888, 1'b0, lat, errs, bb, rd);
        do_req(1'b0, 1'b1, 14'h0020, 64'h0123_4567_89AB_CDEF, 1'b0, lat, errs, bb, rd);
        do_req(1'b1, 1'b0, 14'h0020, 64'h0, 1'b1, lat, errs, bb, rd);
        chk("midop_lat",  64'(lat), 64'(LATENCY));
        chk("midop_data", rd, 64'h0123_4567_89AB_CDEF);
        chk("midop_err",  64'(errs), 64'd0);
        do_req(1'b1, 1'b0, 14'h0030, 64'h0, 1'b0, lat, errs, bb, rd);
        chk("midop_30_intact", rd, 64'h5555_6666_7777_8888);

        // Simultaneous re & we: write wins, req_err pulses once
        do_req(1'b1, 1'b1, 14'h0005, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, lat, errs, bb, rd);
        chk("both_err_pulses", 64'(errs), 64'd1);
        chk("both_lat",        64'(lat), 64'(LATENCY));
        chk("both_rdata_held", rd, 64'h5555_6666_7777_8888);
        do_req(1'b1, 1'b0, 14'h0005, 64'h0, 1'b0, lat, errs, bb, rd);
        chk("both_readback", rd, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("both_rd_err",   64'(errs), 64'd0);

        // Reset two cycles into a write aborts it
        do_req(1'b0, 1'b1, 14'h0007, 64'h0, 1'b0, lat, errs, bb, rd);
        re = 1'b0; we = 1'b1; addr = 14'h0007; wdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        we = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_busy",  {63'd0, busy}, 64'd0);
        chk("rst_mid_rdy",   {63'd0, rdy},  64'd0);
        chk("rst_mid_rdata", rdata, 64'd0);
        rst = 1'b0;
        nrdy = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rdy) nrdy++;
        end
        chk("rst_mid_no_rdy", 64'(nrdy), 64'd0);
        do_req(1'b1, 1'b0, 14'h0007, 64'h0, 1'b0, lat, errs, bb, rd);
        chk("rst_mid_mem_kept", rd, 64'd0);

        // Next request presented in the rdy cycle: held off through DONE,
        // accepted on the following IDLE edge
        do_req(1'b0, 1'b1, 14'h0041, 64'h4141_4141_0041_0041, 1'b0, lat, errs, bb, rd);
        re = 1'b0; we = 1'b1; addr = 14'h0040; wdata = 64'h4040_4040_0040_0040;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (rdy) begin
                lat = n - 1;
                break;
            end
        end
        chk("evict_lat", 64'(lat), 64'(LATENCY));
        we = 1'b0; re = 1'b1; addr = 14'h0041; wdata = '0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 1) chk("fill_not_in_done", {63'd0, busy}, 64'd0);
            if (rdy) begin
                lat = n;
                break;
            end
        end
        chk("fill_lat", 64'(lat), 64'(LATENCY + 2));
        chk("fill_data", rdata, 64'h4141_4141_0041_0041);
        re = 1'b0;
        tick();
        tick();
        chk("fill_rdata_hold_idle", rdata, 64'h4141_4141_0041_0041);
        do_req(1'b1, 1'b0, 14'h0040, 64'h0, 1'b0, lat, errs, bb, rd);
        chk("evict_readback", rd, 64'h4040_4040_0040_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
